// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RVX10 pipeline: operand forwarding,
// load-use stalls, branch flushes, multi-cycle EX sequencing and stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MultiCycleE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MC_INIT = 4'(MC_LAT - 2);

  state_t     state, state_nx;
  logic [3:0] mc_cnt, mc_cnt_nx;
  logic       lwStall;
  logic       mcStall;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != '0) && (rs == rd_m))      return 2'b10;
    else if (we_w && (rd_w != '0) && (rs == rd_w)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  assign lwStall = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mc_cnt <= '0;
    end else begin
      state  <= state_nx;
      mc_cnt <= mc_cnt_nx;
    end
  end

  // BUSY with mc_cnt==0 is the release cycle; MultiCycleE is ignored there so a
  // following op is picked up from IDLE on the next cycle.
  always_comb begin
    state_nx  = state;
    mc_cnt_nx = mc_cnt;
    case (state)
      IDLE: begin
        if (MultiCycleE) begin
          state_nx  = BUSY;
          mc_cnt_nx = MC_INIT;
        end
      end
      BUSY: begin
        if (mc_cnt != '0) mc_cnt_nx = mc_cnt - 4'd1;
        else              state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset also masks mcStall so outputs follow the plain input equations while held.
  always_comb begin
    mcStall = 1'b0;
    case (state)
      IDLE:    mcStall = MultiCycleE;
      BUSY:    mcStall = (mc_cnt != '0);
      default: mcStall = 1'b0;
    endcase
    if (reset) mcStall = 1'b0;

    StallF  = lwStall | mcStall;
    StallD  = lwStall | mcStall;
    StallE  = mcStall;
    FlushM  = mcStall;
    FlushD  = PCSrcE & ~mcStall;
    FlushE  = (lwStall | PCSrcE) & ~mcStall;
    mc_busy = (state == BUSY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF) stall_cnt <= stall_cnt + CNT_W'(1);
      if (FlushD) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed literal checks followed by
// randomized stimulus compared every cycle against a residency-based reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MultiCycleE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: cycles the current op has already spent in E, plus the two counters.
  int unsigned   m_pos = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;

  pipe_hazard_ctrl #(.MC_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .mc_busy(mc_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && rs == RdM) return 2'd2;
    if (RegWriteW && RdW != 0 && rs == RdW) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic m_lw();
    return ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
  endfunction

  // An op is held for its first LAT-1 cycles in E and leaves on cycle LAT.
  function automatic logic m_mc();
    if (reset) return 1'b0;
    return (MultiCycleE || m_pos > 0) && (m_pos < LAT - 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos   = 0;
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (m_lw() || m_mc())  m_stall = m_stall + 1'b1;
      if (PCSrcE && !m_mc()) m_flush = m_flush + 1'b1;
      if (MultiCycleE || m_pos > 0) m_pos = (m_pos == LAT - 1) ? 0 : m_pos + 1;
    end
  end

  always @(negedge clk) begin
    check("ForwardAE", 32'(ForwardAE), 32'(m_fwd(Rs1E)));
    check("ForwardBE", 32'(ForwardBE), 32'(m_fwd(Rs2E)));
    check("StallF",    32'(StallF),    32'(m_lw() | m_mc()));
    check("StallD",    32'(StallD),    32'(m_lw() | m_mc()));
    check("StallE",    32'(StallE),    32'(m_mc()));
    check("FlushM",    32'(FlushM),    32'(m_mc()));
    check("FlushD",    32'(FlushD),    32'(PCSrcE & ~m_mc()));
    check("FlushE",    32'(FlushE),    32'((m_lw() | PCSrcE) & ~m_mc()));
    check("mc_busy",   32'(mc_busy),   32'(m_pos > 0));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MultiCycleE} = '0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst stall_cnt", 32'(stall_cnt), 0);
    check("rst flush_cnt", 32'(flush_cnt), 0);
    check("rst mc_busy",   32'(mc_busy),   0);

    // Forwarding priority
    RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd5;
    #1 check("fwd M prio", 32'(ForwardAE), 2);
    RegWriteM = 1'b0;
    #1 check("fwd W", 32'(ForwardAE), 1);
    RegWriteM = 1'b1; RdM = 5'd0; Rs2E = 5'd0;
    #1 check("fwd x0", 32'(ForwardBE), 0);

    // Load-use
    step(); clear_inputs();
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    check("lu StallF", 32'(StallF), 1);
    check("lu StallD", 32'(StallD), 1);
    check("lu FlushE", 32'(FlushE), 1);
    step(); clear_inputs();
    check("lu stall_cnt", 32'(stall_cnt), 1);
    ResultSrcE0 = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
    #1 check("lu x0 StallF", 32'(StallF), 0);
    step(); clear_inputs();
    check("lu x0 stall_cnt", 32'(stall_cnt), 1);

    // Branch
    PCSrcE = 1'b1;
    #1;
    check("br FlushD", 32'(FlushD), 1);
    check("br FlushE", 32'(FlushE), 1);
    check("br StallE", 32'(StallE), 0);
    step(); clear_inputs();
    check("br flush_cnt", 32'(flush_cnt), 1);

    // Single multi-cycle op: stalled on cycles 1..3, released on cycle 4
    MultiCycleE = 1'b1;
    for (int unsigned c = 1; c <= 4; c++) begin
      #1;
      check("mc StallE", 32'(StallE), (c <= 3) ? 1 : 0);
      check("mc FlushM", 32'(FlushM), (c <= 3) ? 1 : 0);
      if (c <= 3) check("mc busy", 32'(mc_busy), (c >= 2) ? 1 : 0);
      step();
    end
    MultiCycleE = 1'b0;
    check("mc stall_cnt", 32'(stall_cnt), 4);

    // Two back-to-back ops: 6 of 8 cycles stalled
    MultiCycleE = 1'b1;
    for (int unsigned c = 1; c <= 8; c++) step();
    MultiCycleE = 1'b0;
    check("b2b stall_cnt", 32'(stall_cnt), 10);

    // Override: branch and load-use during BUSY must not flush E
    MultiCycleE = 1'b1;
    step();
    PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    #1;
    check("ovr FlushD", 32'(FlushD), 0);
    check("ovr FlushE", 32'(FlushE), 0);
    check("ovr StallE", 32'(StallE), 1);
    step();
    PCSrcE = 1'b0; ResultSrcE0 = 1'b0; RdE = 5'd0; Rs1D = 5'd0;
    step(); step();
    MultiCycleE = 1'b0;
    check("ovr stall_cnt", 32'(stall_cnt), 13);
    check("ovr flush_cnt", 32'(flush_cnt), 1);

    // Reset mid-op on the cycle where one stalled cycle remains
    MultiCycleE = 1'b1;
    step(); step();
    #1 reset = 1'b1;
    #1;
    check("rst mid busy",  32'(mc_busy),   0);
    check("rst mid StallF", 32'(StallF),   0);
    check("rst mid StallE", 32'(StallE),   0);
    check("rst mid stall_cnt", 32'(stall_cnt), 0);
    check("rst mid flush_cnt", 32'(flush_cnt), 0);
    #1 MultiCycleE = 1'b0; reset = 1'b0;
    step();
    check("post rst busy", 32'(mc_busy), 0);
    step();
    check("post rst busy2", 32'(mc_busy), 0);
    check("post rst StallF", 32'(StallF), 0);

    // Randomized phase
    for (int unsigned n = 0; n < 3000; n++) begin
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      ResultSrcE0 = ($urandom_range(0, 3) == 0);
      PCSrcE      = ($urandom_range(0, 3) == 0);
      MultiCycleE = (m_pos > 0) ? 1'b1 : ($urandom_range(0, 4) == 0);
      reset       = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
